// File: rtl/fft_output_streamer.sv
// Unloads FFT results from the result RAM in natural bin order onto a valid/ready stream.
// A 2-entry buffer with credit-gated reads hides the 1-cycle RAM latency at 1 sample/cycle.
module fft_output_streamer #(
    parameter int MAX_N      = 32,
    parameter int ADDR_WIDTH = $clog2(MAX_N),
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_cfg,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q;
    logic [CW-1:0]         n_q;
    logic [CW-1:0]         rd_cnt_q;
    logic [CW-1:0]         xfer_cnt_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic       push;
    logic       pop;
    logic       n_legal;
    logic       last_rd;
    logic [1:0] occ_after_pop;

    assign push          = inflight_q;
    assign out_valid     = (occ_q != 2'd0);
    assign pop           = out_valid & out_ready;
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign occ_d         = occ_q + {1'b0, push} - {1'b0, pop};

    // Credit: buffered samples plus the read in flight must leave room for one more.
    assign rd_en = (state_q == RUN) &&
                   (({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2);

    assign last_rd   = (rd_cnt_q == n_q - CW'(1));
    assign rd_addr   = rd_cnt_q[ADDR_WIDTH-1:0];
    assign out_data  = buf_q[rd_ptr_q];
    assign out_index = xfer_cnt_q[ADDR_WIDTH-1:0];
    assign out_last  = out_valid && (xfer_cnt_q == n_q - CW'(1));
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    assign n_legal = (n_cfg >= CW'(4)) && (n_cfg <= CW'(MAX_N)) &&
                     ((n_cfg & (n_cfg - CW'(1))) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            rd_cnt_q   <= '0;
            xfer_cnt_q <= '0;
            inflight_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (n_legal) begin
                            n_q        <= n_cfg;
                            rd_cnt_q   <= '0;
                            xfer_cnt_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd_en && last_rd) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Only active in RUN/DRAIN, so they never collide with the IDLE clears.
            if (rd_en) begin
                rd_cnt_q <= rd_cnt_q + CW'(1);
            end
            inflight_q <= rd_en;
            if (push) begin
                buf_q[wr_ptr_q] <= rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                xfer_cnt_q <= xfer_cnt_q + CW'(1);
            end
            occ_q <= occ_d;
        end
    end
endmodule

// File: tb/tb_fft_output_streamer.sv
// Scoreboard bench: expected samples are queued at start from a RAM model; a monitor checks transfers.
module tb_fft_output_streamer;
    localparam int MAX_N = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   n_cfg = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    fft_output_streamer #(.MAX_N(MAX_N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .n_cfg(n_cfg),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [MAX_N];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   issued = 0, xfers = 0, job_n = 0, done_cnt = 0;
    int   first_rd_cyc = 0, first_xfer_cyc = 0, last_xfer_cyc = 0, start_cyc = 0;
    int   rmode = 0;
    bit   exp_done_next = 0, err_allowed = 0, hold_vld = 0;
    logic [DW-1:0] hold_dat;
    logic [AW-1:0] hold_idx;
    logic          hold_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops, hold stability, credit, read order, done timing.
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (reset) begin
            hold_vld      = 0;
            exp_done_next = 0;
        end else begin
            if (hold_vld) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_dat);
                chk("hold_index", out_index, hold_idx);
                chk("hold_last", out_last, hold_last);
            end
            chk("done_timing", done, exp_done_next);
            exp_done_next = 0;
            if (err && !err_allowed) chk("spurious_err", err, 0);
            p = (out_valid && out_ready) ? 1 : 0;
            if (rd_en) begin
                chk("rd_addr", rd_addr, issued);
                chk("rd_within_job", issued < job_n, 1);
                chk("credit", (issued - xfers - p) < 2, 1);
                if (issued == 0) first_rd_cyc = cyc;
                issued++;
            end
            if (p == 1) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("out_data", out_data, e.dat);
                    chk("out_index", out_index, e.idx);
                    chk("out_last", out_last, e.last);
                    exp_done_next = e.last;
                end
                if (xfers == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfers++;
            end
            if (done) done_cnt++;
            hold_vld  = out_valid && !out_ready;
            hold_dat  = out_data;
            hold_idx  = out_index;
            hold_last = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic begin_job(input int n, input bit ramp);
        exp_t e;
        for (int i = 0; i < MAX_N; i++) mem[i] = ramp ? DW'(i * 3) : DW'($urandom);
        for (int i = 0; i < n; i++) begin
            e.dat  = mem[i];
            e.idx  = AW'(i);
            e.last = (i == n - 1);
            sb_q.push_back(e);
        end
        issued    = 0;
        xfers     = 0;
        job_n     = n;
        start     = 1'b1;
        n_cfg     = (AW+1)'(n);
        start_cyc = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int d0 = done_cnt;
        int c = 0;
        while (done_cnt == d0 && c < budget) begin
            tick();
            c++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        chk("all_samples", xfers, n);
        chk("sb_drained", sb_q.size(), 0);
        repeat (3) tick();
        chk("done_single", done_cnt - d0, 1);
        chk("no_extra_reads", issued, n);
    endtask

    task automatic wait_xfers(input int k);
        int c = 0;
        while (xfers < k && c < 500) begin
            tick();
            c++;
        end
        chk("reach_sample", xfers >= k, 1);
    endtask

    initial begin
        int bad [6] = '{5, 0, 3, 33, 63, 2};
        int d0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        reset = 1'b0;
        tick();

        // 1: ramp data, N=8, ready held high
        rmode = 0;
        begin_job(8, 1);
        wait_done(8, 200);
        chk("t1_first_rd_cyc", first_rd_cyc, start_cyc + 1);
        chk("t1_first_xfer_cyc", first_xfer_cyc, start_cyc + 3);
        chk("t1_burst_len", last_xfer_cyc - first_xfer_cyc, 7);

        // 2: N=32 with random backpressure
        rmode = 1;
        begin_job(32, 0);
        wait_done(32, 2000);

        // 3: illegal sizes
        rmode = 0;
        err_allowed = 1;
        foreach (bad[i]) begin
            job_n  = 0;
            issued = 0;
            start  = 1'b1;
            n_cfg  = (AW+1)'(bad[i]);
            tick();
            start = 1'b0;
            chk("t3_err_pulse", err, 1);
            chk("t3_busy_low", busy, 0);
            tick();
            chk("t3_err_one_cycle", err, 0);
            repeat (2) tick();
            chk("t3_no_reads", issued, 0);
        end
        err_allowed = 0;

        // 4: start while busy is ignored
        begin_job(16, 0);
        wait_xfers(6);
        start = 1'b1;
        n_cfg = 6'd4;
        tick();
        start = 1'b0;
        chk("t4_err_low", err, 0);
        wait_done(16, 300);

        // 5: reset mid-unload, then a fresh N=4 run
        begin_job(16, 0);
        wait_xfers(9);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_outputs",
            {rd_en, rd_addr, out_valid, out_data, out_index, out_last, busy, done, err}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        job_n  = 0;
        issued = 0;
        xfers  = 0;
        tick();
        chk("t5_no_done_on_abort", done_cnt - d0, 0);
        begin_job(4, 0);
        wait_done(4, 200);

        // 6: consumer stalled for 10 cycles after start
        rmode = 2;
        begin_job(4, 0);
        repeat (10) tick();
        chk("t6_reads_while_stalled", issued, 2);
        chk("t6_valid_held", out_valid, 1);
        chk("t6_index_held", out_index, 0);
        rmode = 0;
        wait_done(4, 200);
        chk("t6_burst_len", last_xfer_cyc - first_xfer_cyc, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
